cipher_group_formatter: RTL and testbench

Downstream of the Enigma cipher core. Takes the core's per-character ciphertext byte and valid pulse and buffers it. Emits the letters as a byte stream in classic 5-letter groups, separated by spaces, with CR LF line breaks. The stream goes to a UART transmitter through a valid/ready handshake. Non-letter codes are discarded; a flush request terminates the current line.

---
 rtl/enigma_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/cipher_group_formatter.sv | 173 +++++++++++++++++
 tb/tb_cipher_group_formatter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// =====================================================================
// enigma_pkg : ASCII constants and formatter FSM encoding
// Revision   : 1.0
// =====================================================================
`default_nettype none

package enigma_pkg;

    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] SP       = 8'h20;
    localparam logic [7:0] LETTER_A = 8'h41;
    localparam logic [7:0] LETTER_Z = 8'h5A;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EMIT_CHAR = 3'd1,
        EMIT_SP   = 3'd2,
        EMIT_CR   = 3'd3,
        EMIT_LF   = 3'd4
    } fmt_state_e;

    function automatic logic is_letter(input logic [7:0] b);
        return (b >= LETTER_A) && (b <= LETTER_Z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// =====================================================================
// sync_fifo : single-clock FIFO with push/pop/full/empty/count
// Revision  : 1.0
// =====================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Full is judged on the pre-pop occupancy, so a push while full is refused
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/cipher_group_formatter.sv
// =====================================================================
// cipher_group_formatter : buffers cipher letters, emits 5-letter groups
// Revision               : 1.0
// =====================================================================
`default_nettype none

module cipher_group_formatter
    import enigma_pkg::*;
#(
    parameter int GROUP_LEN       = 5,
    parameter int GROUPS_PER_LINE = 6,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       flush,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic       busy
);

    localparam int         FAW      = $clog2(FIFO_DEPTH);
    localparam logic [3:0] GL       = 4'(GROUP_LEN);
    localparam logic [3:0] GPL_LAST = 4'(GROUPS_PER_LINE - 1);

    fmt_state_e  state_q, state_d;
    logic [3:0]  char_cnt_q, char_cnt_d;
    logic [3:0]  grp_cnt_q, grp_cnt_d;
    logic        flush_pend_q, flush_pend_d;
    logic        from_flush_q, from_flush_d;
    logic        overflow_q, overflow_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;

    logic        letter_in;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [FAW:0] fifo_count;
    logic        handshake;

    assign letter_in = in_valid && is_letter(in_data);
    assign fifo_push = letter_in && !fifo_full;
    assign handshake = out_valid_q && out_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        char_cnt_d   = char_cnt_q;
        grp_cnt_d    = grp_cnt_q;
        flush_pend_d = flush_pend_q || flush;
        from_flush_d = from_flush_q;
        overflow_d   = overflow_q || (letter_in && fifo_full);
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        fifo_pop     = 1'b0;

        case (state_q)
            IDLE: begin
                // Buffered letters always go out before a pending flush is served
                if (!fifo_empty) begin
                    out_valid_d  = 1'b1;
                    from_flush_d = 1'b0;
                    if (char_cnt_q == GL && grp_cnt_q == GPL_LAST) begin
                        state_d    = EMIT_CR;
                        out_data_d = CR;
                    end else if (char_cnt_q == GL) begin
                        state_d    = EMIT_SP;
                        out_data_d = SP;
                    end else begin
                        state_d    = EMIT_CHAR;
                        out_data_d = fifo_head;
                    end
                end else if (flush_pend_q) begin
                    if (char_cnt_q != '0 || grp_cnt_q != '0) begin
                        state_d      = EMIT_CR;
                        out_data_d   = CR;
                        out_valid_d  = 1'b1;
                        from_flush_d = 1'b1;
                    end else begin
                        flush_pend_d = 1'b0;
                    end
                end
            end
            EMIT_CHAR: begin
                if (handshake) begin
                    fifo_pop    = 1'b1;
                    char_cnt_d  = char_cnt_q + 4'd1;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            EMIT_SP: begin
                if (handshake) begin
                    char_cnt_d  = '0;
                    grp_cnt_d   = grp_cnt_q + 4'd1;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            EMIT_CR: begin
                if (handshake) begin
                    out_data_d = LF;
                    state_d    = EMIT_LF;
                end
            end
            EMIT_LF: begin
                if (handshake) begin
                    char_cnt_d   = '0;
                    grp_cnt_d    = '0;
                    out_valid_d  = 1'b0;
                    state_d      = IDLE;
                    from_flush_d = 1'b0;
                    if (from_flush_q) flush_pend_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            char_cnt_q   <= '0;
            grp_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            from_flush_q <= 1'b0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            char_cnt_q   <= char_cnt_d;
            grp_cnt_q    <= grp_cnt_d;
            flush_pend_q <= flush_pend_d;
            from_flush_q <= from_flush_d;
            overflow_q   <= overflow_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;
    assign busy      = (fifo_count != '0) || (state_q != IDLE) || flush_pend_q;

endmodule

`default_nettype wire

// File: tb/tb_cipher_group_formatter.sv
// =====================================================================
// tb_cipher_group_formatter : scoreboard bench for the group formatter
// Revision                  : 1.0
// =====================================================================
`default_nettype none

module tb_cipher_group_formatter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       overflow;
    logic       busy;

    int checks = 0;
    int passed = 0;
    logic [7:0] sb[$];

    cipher_group_formatter #(
        .GROUP_LEN       (5),
        .GROUPS_PER_LINE (6),
        .FIFO_DEPTH      (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        chk(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        chk(out_data == 8'h00, "reset_out_data", out_data, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(overflow == 1'b0, "reset_overflow", overflow, 0);
    endtask

    task automatic wait_drain(input string name, input bit rnd_ready);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 2000) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        chk(n < 2000, {name, "_drain_timeout"}, n, 2000);
        chk(sb.size() == 0, {name, "_missing_bytes"}, sb.size(), 0);
    endtask

    // Monitor: scoreboard pop on every handshake, plus stall stability
    initial begin
        logic [7:0] held;
        logic [7:0] e;
        bit         stalled;
        stalled = 1'b0;
        held    = 8'h00;
        forever begin
            @(negedge clock);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk(out_valid == 1'b1, "valid_dropped_in_stall", out_valid, 1);
                    chk(out_data == held, "data_changed_in_stall", out_data, held);
                end
                if (out_valid && out_ready) begin
                    chk(sb.size() != 0, "unexpected_byte", out_data, 0);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk(out_data == e, "stream_byte", out_data, e);
                    end
                end
                stalled = out_valid && !out_ready;
                held    = out_data;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: ten letters, one group break, no trailing separator
        do_reset();
        expect_str("HELLO WORLD");
        send_str("HELLOWORLD", 0);
        wait_drain("helloworld", 1'b0);

        // Test 2: line wrap after six groups
        do_reset();
        expect_str("ABCDE FGHIJ KLMNO PQRST UVWXY ZABCD\r\nE");
        send_str("ABCDEFGHIJKLMNOPQRSTUVWXYZABCDE", 2);
        wait_drain("wrap", 1'b0);
        chk(overflow == 1'b0, "wrap_no_overflow", overflow, 0);

        // Test 3: flush ends the line; second flush on a clean line is silent
        do_reset();
        expect_str("AB\r\n");
        send_str("AB", 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain("flush", 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk(busy == 1'b1, "flush2_pending_busy", busy, 1);
        tick();
        chk(busy == 1'b0, "flush2_cleared_busy", busy, 0);
        repeat (4) tick();
        chk(out_valid == 1'b0, "flush2_no_output", out_valid, 0);

        // Test 4: letter filter boundaries
        do_reset();
        expect_str("AZ");
        send(8'h61, 0);
        send(8'h20, 0);
        send(8'h5B, 0);
        send(8'h40, 0);
        send(8'h41, 0);
        send(8'h5A, 0);
        wait_drain("filter", 1'b0);

        // Test 5: overflow while stalled, then drain with a toggling ready
        do_reset();
        out_ready = 1'b0;
        expect_str("ABCDE FGHIJ KLMNO P");
        send_str("ABCDEFGHIJKLMNOPQ", 0);
        chk(overflow == 1'b1, "overflow_set", overflow, 1);
        chk(out_valid == 1'b1 && out_data == 8'h41, "stall_head_A", out_data, 8'h41);
        wait_drain("overflow", 1'b1);
        chk(overflow == 1'b1, "overflow_sticky", overflow, 1);

        // Test 6: reset while LF is presented with the FIFO half full
        do_reset();
        expect_str("ABCDE FGHIJ KLMNO PQRST UVWXY ZABCD");
        send_str("ABCDEFGHIJKLMNOPQRSTUVWXYZABCD", 2);
        wait_drain("prewrap", 1'b0);
        out_ready = 1'b0;
        sb.push_back(8'h0D);
        send_str("FGHIJKLM", 0);
        repeat (2) tick();
        chk(out_valid == 1'b1 && out_data == 8'h0D, "cr_presented", out_data, 8'h0D);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk(out_valid == 1'b1 && out_data == 8'h0A, "lf_presented", out_data, 8'h0A);
        chk(busy == 1'b1, "busy_before_reset", busy, 1);
        do_reset();
        out_ready = 1'b1;
        expect_str("X");
        send(8'h58, 0);
        wait_drain("post_reset", 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
